// File: rtl/seg_display_if.sv
// Display-sharing bus: requester-side request/data lines and the arbiter's
// registered display outputs.
interface seg_display_if;
  logic [2:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [2:0]  ack;
  logic [15:0] disp_data;
  logic [1:0]  disp_owner;
  logic        disp_valid;
  logic        busy;

  modport master (
    output req, data0, data1, data2,
    input  ack, disp_data, disp_owner, disp_valid, busy
  );

  modport slave (
    input  req, data0, data1, data2,
    output ack, disp_data, disp_owner, disp_valid, busy
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit display with a minimum dwell time.
// Optional build macro SEG_ARB_BLANK_IDLE_EN blanks disp_data on entry to IDLE.
module seg_display_arbiter #(
  parameter int unsigned DWELL_CYCLES = 5000000,
  parameter int unsigned CNT_W        = 23
) (
  input  logic          clk,
  input  logic          reset,
  seg_display_if.slave  bus
);

  typedef enum logic {IDLE, SHOW} state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Search starts after the last owner; the last owner itself is tried last.
  function automatic pick_t rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] c1;
    logic [1:0] c2;
    pick_t      p;
    c1 = next_idx(last);
    c2 = next_idx(c1);
    p  = '{found: 1'b1, idx: last};
    if      (req[c1])   p.idx   = c1;
    else if (req[c2])   p.idx   = c2;
    else if (req[last]) p.idx   = last;
    else                p.found = 1'b0;
    return p;
  endfunction

  function automatic logic [15:0] sel_data(input logic [1:0] i, input logic [15:0] d0,
                                           input logic [15:0] d1, input logic [15:0] d2);
    logic [15:0] d;
    case (i)
      2'd0:    d = d0;
      2'd1:    d = d1;
      default: d = d2;
    endcase
    return d;
  endfunction

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]  last_owner_q, last_owner_d;
  logic [1:0]  disp_owner_q, disp_owner_d;
  logic [15:0] disp_data_q, disp_data_d;
  logic [2:0]  ack_q, ack_d;

  pick_t       pick;
  logic [15:0] win_data;
  logic [15:0] own_data;

  always_comb begin
    pick     = rr_pick(last_owner_q, bus.req);
    win_data = sel_data(pick.idx, bus.data0, bus.data1, bus.data2);
    own_data = sel_data(last_owner_q, bus.data0, bus.data1, bus.data2);
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves a latch behind.
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    disp_owner_d = disp_owner_q;
    disp_data_d  = disp_data_q;
    ack_d        = '0;

    unique case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d      = SHOW;
          cnt_d        = RELOAD;
          last_owner_d = pick.idx;
          disp_owner_d = pick.idx;
          disp_data_d  = win_data;
          ack_d        = 3'b001 << pick.idx;
        end
      end
      SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (bus.req[last_owner_q]) disp_data_d = own_data;
        end else if (pick.found) begin
          // Re-grant to the same owner renews the dwell silently, without an ack.
          cnt_d        = RELOAD;
          disp_data_d  = win_data;
          last_owner_d = pick.idx;
          disp_owner_d = pick.idx;
          if (pick.idx != last_owner_q) ack_d = 3'b001 << pick.idx;
        end else begin
          state_d = IDLE;
`ifdef SEG_ARB_BLANK_IDLE_EN
          disp_data_d = '0;
`else
          disp_data_d = disp_data_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_owner_q <= 2'd2;
      disp_owner_q <= 2'd0;
      disp_data_q  <= 16'h0000;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      disp_owner_q <= disp_owner_d;
      disp_data_q  <= disp_data_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_owner = disp_owner_q;
  assign bus.disp_valid = (state_q == SHOW);
  assign bus.busy       = (state_q == SHOW);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter at DWELL_CYCLES=4: a cycle model
// queues expected outputs per edge, compared after the edge.
module tb_seg_display_arbiter;

  localparam int DWELL = 4;

  logic clk;
  logic reset;

  seg_display_if bus ();

  seg_display_arbiter #(.DWELL_CYCLES(DWELL), .CNT_W(23)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ack;
    logic [15:0] data;
    logic [1:0]  owner;
    logic        valid;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_show;
  int          m_cnt;
  int          m_last;
  int          m_owner;
  logic [15:0] m_data;
  logic [2:0]  m_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] src(input int i);
    if (i == 0) return bus.data0;
    if (i == 1) return bus.data1;
    return bus.data2;
  endfunction

  function automatic int rr(input int last, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_edge();
    exp_t e;
    int   w;
    m_ack = 3'b000;
    if (reset) begin
      m_show = 0; m_cnt = 0; m_last = 2; m_owner = 0; m_data = 16'h0000;
    end else if (!m_show) begin
      w = rr(m_last, bus.req);
      if (w >= 0) begin
        m_show = 1; m_cnt = DWELL - 1; m_last = w; m_owner = w;
        m_data = src(w); m_ack[w] = 1'b1;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (bus.req[m_last]) m_data = src(m_last);
    end else begin
      w = rr(m_last, bus.req);
      if (w < 0) begin
        m_show = 0;
`ifdef SEG_ARB_BLANK_IDLE_EN
        m_data = 16'h0000;
`endif
      end else begin
        if (w != m_last) m_ack[w] = 1'b1;
        m_last = w; m_owner = w; m_cnt = DWELL - 1; m_data = src(w);
      end
    end
    e.ack = m_ack; e.data = m_data; e.owner = 2'(m_owner);
    e.valid = m_show; e.busy = m_show;
    sb.push_back(e);
  endtask

  // One clock: queue the prediction, take the edge, compare just after it.
  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("ack",   32'(bus.ack),        32'(e.ack));
      check("data",  32'(bus.disp_data),  32'(e.data));
      check("owner", 32'(bus.disp_owner), 32'(e.owner));
      check("valid", 32'(bus.disp_valid), 32'(e.valid));
      check("busy",  32'(bus.busy),       32'(e.busy));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.req = 3'b000;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 3'b000; bus.data0 = 16'h0; bus.data1 = 16'h0; bus.data2 = 16'h0;

    // 1: reset for 3 cycles, then idle hold
    repeat (3) step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("t1_data",  32'(bus.disp_data), 32'h0000);
      check("t1_valid", 32'(bus.disp_valid), 32'd0);
      check("t1_ack",   32'(bus.ack), 32'd0);
      check("t1_owner", 32'(bus.disp_owner), 32'd0);
      check("t1_busy",  32'(bus.busy), 32'd0);
    end

    // 2: single grant, request dropped after one cycle
    do_reset();
    bus.data0 = 16'h1234; bus.req = 3'b001;
    step();
    check("t2_ack1",   32'(bus.ack), 32'b001);
    check("t2_valid1", 32'(bus.disp_valid), 32'd1);
    check("t2_data1",  32'(bus.disp_data), 32'h1234);
    check("t2_owner1", 32'(bus.disp_owner), 32'd0);
    bus.req = 3'b000;
    repeat (3) step();
    check("t2_valid4", 32'(bus.disp_valid), 32'd1);
    step();
    check("t2_valid5", 32'(bus.disp_valid), 32'd0);
`ifdef SEG_ARB_BLANK_IDLE_EN
    check("t2_data5", 32'(bus.disp_data), 32'h0000);
`else
    check("t2_data5", 32'(bus.disp_data), 32'h1234);
`endif

    // 3: all three request continuously -> rotation 0,1,2,0
    do_reset();
    bus.data0 = 16'h000A; bus.data1 = 16'h000B; bus.data2 = 16'h000C; bus.req = 3'b111;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c % 4 == 1) begin
        int o;
        o = ((c - 1) / 4) % 3;
        check("t3_owner", 32'(bus.disp_owner), 32'(o));
        check("t3_ack",   32'(bus.ack), 32'(1 << o));
        check("t3_data",  32'(bus.disp_data), 32'(16'h000A + o));
      end else begin
        check("t3_noack", 32'(bus.ack), 32'd0);
      end
    end

    // 4: live update and silent re-dwell of a lone requester
    do_reset();
    bus.data1 = 16'h00AA; bus.req = 3'b010;
    step();
    check("t4_ack1",  32'(bus.ack), 32'b010);
    check("t4_data1", 32'(bus.disp_data), 32'h00AA);
    step();
    bus.data1 = 16'h00BB;
    step();
    check("t4_data3", 32'(bus.disp_data), 32'h00BB);
    step(); step();
    check("t4_ack5",   32'(bus.ack), 32'd0);
    check("t4_owner5", 32'(bus.disp_owner), 32'd1);
    check("t4_valid5", 32'(bus.disp_valid), 32'd1);
    repeat (5) step();

    // 5: owner drops, a mid-dwell pulse from source 2 is not remembered
    do_reset();
    bus.data0 = 16'h0055; bus.req = 3'b001;
    step();
    bus.data0 = 16'h0066;
    step();
    check("t5_live", 32'(bus.disp_data), 32'h0066);
    bus.req = 3'b000; bus.data0 = 16'h0077;
    step();
    check("t5_frozen3", 32'(bus.disp_data), 32'h0066);
    bus.req = 3'b100; bus.data2 = 16'h0099;
    step();
    check("t5_frozen4", 32'(bus.disp_data), 32'h0066);
    check("t5_valid4",  32'(bus.disp_valid), 32'd1);
    bus.req = 3'b000;
    step();
    check("t5_busy5", 32'(bus.busy), 32'd0);
    check("t5_ack5",  32'(bus.ack), 32'd0);
    step();
    check("t5_valid6", 32'(bus.disp_valid), 32'd0);
    check("t5_ack6",   32'(bus.ack), 32'd0);

    // 6: reset in the middle of a source 1 dwell
    do_reset();
    bus.data0 = 16'h0010; bus.data1 = 16'h0011; bus.req = 3'b010;
    step();
    check("t6_owner1", 32'(bus.disp_owner), 32'd1);
    step(); step();
    reset = 1'b1; bus.req = 3'b011;
    step();
    check("t6_valid_rst", 32'(bus.disp_valid), 32'd0);
    check("t6_data_rst",  32'(bus.disp_data), 32'h0000);
    check("t6_owner_rst", 32'(bus.disp_owner), 32'd0);
    check("t6_ack_rst",   32'(bus.ack), 32'd0);
    reset = 1'b0;
    step();
    check("t6_owner", 32'(bus.disp_owner), 32'd0);
    check("t6_ack",   32'(bus.ack), 32'b001);
    check("t6_data",  32'(bus.disp_data), 32'h0010);

    // Random request/data traffic checked against the model
    for (int c = 0; c < 200; c++) begin
      bus.req   = 3'($urandom_range(0, 7));
      bus.data0 = 16'($urandom);
      bus.data1 = 16'($urandom);
      bus.data2 = 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
